// File: rtl/prog_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_div_pkg
// Description : Shared constants, half-period type and channel FSM states for
//               the programmable even-ratio clock divider.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_div_pkg;

    localparam int c_CNT_W    = 8;
    localparam int c_DEF_HALF = 1;

    typedef logic [c_CNT_W-1:0] half_t;

    // IDLE: channel disabled; RUN_HI / RUN_LO: divided clock high / low phase
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_HI = 2'd1,
        RUN_LO = 2'd2
    } ch_state_e;

endpackage
`default_nettype wire

// File: rtl/prog_even_clk_div_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_even_clk_div_if
// Description : Control/status bundle of the multi-channel divider. The
//               master drives enables, loads and error clear; the slave
//               (divider) drives divided clocks, errors and in-effect halves.
//               Optional macro DIV_TICK_EN adds the per-channel tick output.
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_even_clk_div_if
    import prog_div_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = c_CNT_W
) ();

    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH*CNT_W-1:0] half_in;
    logic                    err_clr;
    logic [NUM_CH-1:0]       clk_div;
    logic [NUM_CH-1:0]       err;
    logic [NUM_CH*CNT_W-1:0] cur_half;
`ifdef DIV_TICK_EN
    logic [NUM_CH-1:0]       tick;

    modport master (
        output ch_en, load, half_in, err_clr,
        input  clk_div, err, cur_half, tick
    );

    modport slave (
        input  ch_en, load, half_in, err_clr,
        output clk_div, err, cur_half, tick
    );
`else
    modport master (
        output ch_en, load, half_in, err_clr,
        input  clk_div, err, cur_half
    );

    modport slave (
        input  ch_en, load, half_in, err_clr,
        output clk_div, err, cur_half
    );
`endif

endinterface
`default_nettype wire

// File: rtl/prog_div_ch.sv
`default_nettype none
// ============================================================================
// Module      : prog_div_ch
// Description : One divider channel: half-period counter, pending-ratio
//               register, IDLE/RUN_HI/RUN_LO FSM and sticky illegal-load flag.
//               New ratios are adopted only at the high->low toggle so the
//               output never carries a runt pulse. Optional macro
//               DIV_TICK_EN adds o_tick, a pulse coincident with each rise.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_div_ch
    import prog_div_pkg::*;
#(
    parameter int CNT_W    = c_CNT_W,
    parameter int DEF_HALF = c_DEF_HALF
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_ch_en,
    input  wire logic             i_load,
    input  wire logic [CNT_W-1:0] i_half,
    input  wire logic             i_err_clr,
    output logic                  o_clk_div,
    output logic                  o_err,
`ifdef DIV_TICK_EN
    output logic                  o_tick,
`endif
    output logic [CNT_W-1:0]      o_cur_half
);

    ch_state_e        r_state,    w_state_nxt;
    logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
    logic [CNT_W-1:0] r_cur_half, w_cur_half_nxt;
    logic [CNT_W-1:0] r_pend,     w_pend_nxt;
    logic             r_pend_v,   w_pend_v_nxt;
    logic             r_clk_div,  w_clk_div_nxt;
    logic             r_err,      w_err_nxt;
    logic             r_tick,     w_tick_nxt;
    logic             w_load_ok;
    logic             w_load_bad;
    logic             w_toggle;

    // Next-state, counter, ratio bookkeeping and error flag for one channel
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt + 1'b1;
        w_cur_half_nxt = r_cur_half;
        w_pend_nxt     = r_pend;
        w_pend_v_nxt   = r_pend_v;
        w_clk_div_nxt  = r_clk_div;
        w_tick_nxt     = 1'b0;
        w_load_ok      = i_load && (i_half != '0);
        w_load_bad     = i_load && (i_half == '0);
        w_toggle       = (r_cnt == (r_cur_half - 1'b1));

        // An illegal load in the same cycle as a clear keeps the flag set
        w_err_nxt = r_err;
        if (w_load_bad) begin
            w_err_nxt = 1'b1;
        end else if (i_err_clr) begin
            w_err_nxt = 1'b0;
        end

        if (!i_ch_en) begin
            // Disabled: force low, and adopt any new or pending ratio now
            w_state_nxt   = IDLE;
            w_cnt_nxt     = '0;
            w_clk_div_nxt = 1'b0;
            w_pend_v_nxt  = 1'b0;
            if (w_load_ok) begin
                w_cur_half_nxt = i_half;
            end else if (r_pend_v) begin
                w_cur_half_nxt = r_pend;
            end
        end else begin
            case (r_state)
                IDLE, RUN_LO: begin
                    // IDLE always holds cnt=0, so start-up is a fresh low phase
                    if (w_toggle) begin
                        w_state_nxt   = RUN_HI;
                        w_cnt_nxt     = '0;
                        w_clk_div_nxt = 1'b1;
                        w_tick_nxt    = 1'b1;
                    end else begin
                        w_state_nxt   = RUN_LO;
                    end
                    if (w_load_ok) begin
                        w_pend_nxt   = i_half;
                        w_pend_v_nxt = 1'b1;
                    end
                end
                RUN_HI: begin
                    if (w_toggle) begin
                        // Period boundary: a same-cycle load beats the pending value
                        w_state_nxt   = RUN_LO;
                        w_cnt_nxt     = '0;
                        w_clk_div_nxt = 1'b0;
                        w_pend_v_nxt  = 1'b0;
                        if (w_load_ok) begin
                            w_cur_half_nxt = i_half;
                        end else if (r_pend_v) begin
                            w_cur_half_nxt = r_pend;
                        end
                    end else if (w_load_ok) begin
                        w_pend_nxt   = i_half;
                        w_pend_v_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = '0;
                    w_clk_div_nxt = 1'b0;
                end
            endcase
        end
    end

    // Channel state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_cur_half <= CNT_W'(DEF_HALF);
            r_pend     <= '0;
            r_pend_v   <= 1'b0;
            r_clk_div  <= 1'b0;
            r_err      <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cur_half <= w_cur_half_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_v   <= w_pend_v_nxt;
            r_clk_div  <= w_clk_div_nxt;
            r_err      <= w_err_nxt;
            r_tick     <= w_tick_nxt;
        end
    end

    assign o_clk_div  = r_clk_div;
    assign o_err      = r_err;
    assign o_cur_half = r_cur_half;
`ifdef DIV_TICK_EN
    assign o_tick     = r_tick;
`else
    logic w_unused;
    assign w_unused = r_tick;
`endif

endmodule
`default_nettype wire

// File: rtl/prog_even_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : prog_even_clk_div
// Description : Multi-channel programmable even-ratio (2*half) 50%-duty clock
//               divider. Replicates one prog_div_ch per channel and slices the
//               packed half-period buses. Optional macro DIV_TICK_EN adds a
//               per-channel rising-edge tick output.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_even_clk_div
    import prog_div_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int CNT_W    = c_CNT_W,
    parameter int DEF_HALF = c_DEF_HALF
) (
    input  wire logic          clk,
    input  wire logic          rst,
    prog_even_clk_div_if.slave bus
);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            prog_div_ch #(
                .CNT_W    (CNT_W),
                .DEF_HALF (DEF_HALF)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .i_ch_en    (bus.ch_en[i]),
                .i_load     (bus.load[i]),
                .i_half     (bus.half_in[i*CNT_W +: CNT_W]),
                .i_err_clr  (bus.err_clr),
                .o_clk_div  (bus.clk_div[i]),
                .o_err      (bus.err[i]),
`ifdef DIV_TICK_EN
                .o_tick     (bus.tick[i]),
`endif
                .o_cur_half (bus.cur_half[i*CNT_W +: CNT_W])
            );
        end
    endgenerate

endmodule
`default_nettype wire
